// File: rtl/data_memory_responder.sv
// Memory-side responder: registered instruction fetch port plus a request/ready
// data port with configurable read/write wait states over a shared inout bus.
module data_memory_responder #(
  parameter int    ADDR_W        = 12,
  parameter int    DATA_W        = 16,
  parameter int    DEPTH_WORDS   = 2048,
  parameter int    READ_LATENCY  = 1,
  parameter int    WRITE_LATENCY = 1,
  parameter string INIT_FILE     = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Instruction_addressbus,
  output logic [DATA_W-1:0] Instruction_databus,
  input  logic [ADDR_W-1:0] Memory_addressbus,
  inout  wire  [DATA_W-1:0] Memory_databus,
  input  logic              Memory_writemode,
  input  logic              Memory_request,
  output logic              Memory_ready,
  output logic              Memory_conflict
);

  localparam int IDX_W   = ADDR_W - 1;
  localparam int LAT_MAX = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);
  localparam logic [CNT_W-1:0] RD_WAIT = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_WAIT = CNT_W'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, COMMIT} state_t;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              accept;
  logic              load_rd;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  cap_idx;
  logic              cap_we;
  logic [DATA_W-1:0] cap_data;
  logic [DATA_W-1:0] rdata;
  logic              drive_en;
  logic              unused_lsb;

  initial begin
    for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem[i] = '0;
  end

  assign unused_lsb = ^{Memory_addressbus[0], Instruction_addressbus[0]};

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (Memory_request) begin
          accept = 1'b1;
          if (Memory_writemode) begin
            state_next = (WRITE_LATENCY == 1) ? COMMIT : WAIT;
            cnt_next   = WR_WAIT;
          end else begin
            state_next = (READ_LATENCY == 1) ? RESP : WAIT;
            cnt_next   = RD_WAIT;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_next = cap_we ? COMMIT : RESP;
      end
      RESP:    state_next = IDLE;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read word is fetched on the edge entering RESP so the array sees a
  // registered read; at latency 1 that address is the live bus, else the captured one.
  assign load_rd = (state_next == RESP) && (state != RESP);
  assign rd_idx  = (state == IDLE) ? Memory_addressbus[ADDR_W-1:1] : cap_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      cnt                 <= '0;
      Instruction_databus <= '0;
      Memory_conflict     <= 1'b0;
    end else begin
      state               <= state_next;
      cnt                 <= cnt_next;
      Instruction_databus <= mem[Instruction_addressbus[ADDR_W-1:1]];
      if (state == RESP && Memory_writemode) Memory_conflict <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_idx  <= Memory_addressbus[ADDR_W-1:1];
      cap_we   <= Memory_writemode;
      cap_data <= Memory_databus;
    end
    if (load_rd) rdata <= mem[rd_idx];
    if (state == COMMIT && !rst) mem[cap_idx] <= cap_data;
  end

  assign Memory_ready   = (state == RESP) || (state == COMMIT);
  assign drive_en       = (state == RESP) && !Memory_writemode;
  assign Memory_databus = drive_en ? rdata : 'z;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: two instances (latency 1/1 and 3/4), a
// timestamp-based transaction model, a per-cycle compare process, and directed literal checks.
module tb_data_memory_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0]       req, we, oe;
  logic [1:0][11:0] maddr, iaddr;
  logic [1:0][15:0] wdata, instr, busv;
  logic [1:0]       ready, conflict;
  wire  [15:0]      bus0, bus1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Released bus reads as all ones through the pull-ups.
  pullup (bus0);
  pullup (bus1);
  assign bus0 = oe[0] ? wdata[0] : 16'hzzzz;
  assign bus1 = oe[1] ? wdata[1] : 16'hzzzz;
  assign busv[0] = bus0;
  assign busv[1] = bus1;

  data_memory_responder #(.READ_LATENCY(1), .WRITE_LATENCY(1)) dut0 (
    .clk(clk), .rst(rst),
    .Instruction_addressbus(iaddr[0]), .Instruction_databus(instr[0]),
    .Memory_addressbus(maddr[0]), .Memory_databus(bus0),
    .Memory_writemode(we[0]), .Memory_request(req[0]),
    .Memory_ready(ready[0]), .Memory_conflict(conflict[0])
  );

  data_memory_responder #(.READ_LATENCY(3), .WRITE_LATENCY(4)) dut1 (
    .clk(clk), .rst(rst),
    .Instruction_addressbus(iaddr[1]), .Instruction_databus(instr[1]),
    .Memory_addressbus(maddr[1]), .Memory_databus(bus1),
    .Memory_writemode(we[1]), .Memory_request(req[1]),
    .Memory_ready(ready[1]), .Memory_conflict(conflict[1])
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Transaction model: an access accepted in cycle n-1 has its single response
  // cycle at n-1+latency, where n counts clock edges.
  int          lat_r [2] = '{1, 3};
  int          lat_w [2] = '{1, 4};
  logic [15:0] mem_m [2][2048];
  int          cyc = 0;
  bit          armed = 0;
  bit          active [2];
  int          resp_at [2];
  bit          m_we [2];
  int          m_idx [2];
  logic [15:0] m_data [2];
  logic [15:0] m_instr [2];
  bit          m_conf [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 2048; i++) mem_m[d][i] = 16'h0000;
      active[d] = 0;
    end
  end

  always @(posedge clk) begin
    bit finished;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        armed      = 1;
        active[d]  = 0;
        m_instr[d] = 16'h0000;
        m_conf[d]  = 0;
      end else begin
        m_instr[d] = mem_m[d][iaddr[d][11:1]];
        finished   = 0;
        if (active[d] && cyc - 1 == resp_at[d]) begin
          if (m_we[d]) mem_m[d][m_idx[d]] = m_data[d];
          else if (we[d]) m_conf[d] = 1;
          active[d] = 0;
          finished  = 1;
        end
        if (!active[d] && !finished && req[d]) begin
          active[d]  = 1;
          m_we[d]    = we[d];
          m_idx[d]   = int'(maddr[d][11:1]);
          m_data[d]  = busv[d];
          resp_at[d] = cyc + (we[d] ? lat_w[d] : lat_r[d]) - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit          e_ready;
    logic [15:0] e_bus;
    if (armed) begin
      for (int d = 0; d < 2; d++) begin
        e_ready = active[d] && (cyc == resp_at[d]);
        e_bus   = (e_ready && !m_we[d] && !we[d]) ? mem_m[d][m_idx[d]] : 16'hFFFF;
        chk($sformatf("model_ready%0d@%0d", d, cyc), {31'd0, ready[d]}, {31'd0, e_ready});
        chk($sformatf("model_instr%0d@%0d", d, cyc), {16'd0, instr[d]}, {16'd0, m_instr[d]});
        chk($sformatf("model_conflict%0d@%0d", d, cyc), {31'd0, conflict[d]}, {31'd0, m_conf[d]});
        if (!oe[d]) chk($sformatf("model_bus%0d@%0d", d, cyc), {16'd0, busv[d]}, {16'd0, e_bus});
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input int d, input logic w, input logic [11:0] a, input logic [15:0] v);
    req[d] = 1'b1; we[d] = w; maddr[d] = a; wdata[d] = v; oe[d] = w;
    step();
    req[d] = 1'b0; we[d] = 1'b0; oe[d] = 1'b0;
  endtask

  task automatic access(input int d, input logic w, input logic [11:0] a, input logic [15:0] v,
                        input int exp_lat, input logic [15:0] exp_val, input string name);
    int          lat;
    logic [15:0] val;
    issue(d, w, a, v);
    lat = 0;
    val = 16'h0000;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (ready[d]) begin
        lat = k;
        val = busv[d];
        break;
      end
    end
    step();
    chk({name, "_latency"}, lat, exp_lat);
    if (!w) chk({name, "_data"}, {16'd0, val}, {16'd0, exp_val});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] fetch_img [3];
    logic [3:0]  pat;
    logic [15:0] held_val;
    bit          seen;
    fetch_img[0] = 16'h3001; fetch_img[1] = 16'h4002; fetch_img[2] = 16'hE003;

    req = '0; we = '0; oe = '0; maddr = '0; iaddr = '0; wdata = '0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_instr", {16'd0, instr[0]}, 32'h0);
    chk("reset_ready", {31'd0, ready[0]}, 32'h0);
    chk("reset_bus_released", {16'd0, busv[0]}, 32'hFFFF);
    chk("reset_conflict", {31'd0, conflict[0]}, 32'h0);
    step();

    // Storage survives reset
    access(0, 1'b1, 12'h00A, 16'h1234, 1, 16'h0, "preload_w5");
    rst = 1'b1; step(); rst = 1'b0;
    access(0, 1'b0, 12'h00A, 16'h0, 1, 16'h1234, "w5_after_reset");

    // Write then read same word through odd address
    access(0, 1'b1, 12'h00A, 16'hBEEF, 1, 16'h0, "write_beef");
    access(0, 1'b0, 12'h00B, 16'h0, 1, 16'hBEEF, "read_odd_addr");

    // Fetch port
    for (int i = 0; i < 3; i++)
      access(0, 1'b1, 12'(2 * i), fetch_img[i], 1, 16'h0, $sformatf("img_w%0d", i));
    for (int i = 0; i < 3; i++) begin
      iaddr[0] = 12'(2 * i);
      step();
      @(negedge clk);
      chk($sformatf("fetch_%0d", i), {16'd0, instr[0]}, {16'd0, fetch_img[i]});
    end
    @(posedge clk); #1;

    // Commit and fetch of the same word at one edge
    iaddr[0] = 12'h002;
    issue(0, 1'b1, 12'h002, 16'hFFFF);
    @(negedge clk);
    chk("commit_ready", {31'd0, ready[0]}, 32'h1);
    step();
    @(negedge clk);
    chk("fetch_rbw_old", {16'd0, instr[0]}, 32'h4002);
    step();
    @(negedge clk);
    chk("fetch_rbw_new", {16'd0, instr[0]}, 32'hFFFF);
    step();

    // Request held high through ready starts a second access
    req[0] = 1'b1; we[0] = 1'b0; maddr[0] = 12'h00A;
    pat = '0; held_val = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pat[i] = ready[0];
      if (ready[0]) held_val = busv[0];
      @(posedge clk); #1;
    end
    req[0] = 1'b0;
    chk("held_ready_pattern", {28'd0, pat}, 32'hA);
    chk("held_data", {16'd0, held_val}, 32'hBEEF);
    step();

    // Writemode raised during the read response
    issue(0, 1'b0, 12'h004, 16'h0);
    we[0] = 1'b1;
    @(negedge clk);
    chk("conflict_ready", {31'd0, ready[0]}, 32'h1);
    chk("conflict_bus_released", {16'd0, busv[0]}, 32'hFFFF);
    step();
    we[0] = 1'b0;
    step(); step();
    @(negedge clk);
    chk("conflict_sticky", {31'd0, conflict[0]}, 32'h1);
    step();

    // Wait states on the slow instance
    access(1, 1'b1, 12'h080, 16'hA5A5, 4, 16'h0, "slow_write");
    issue(1, 1'b0, 12'h080, 16'h0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("slow_ready_T%0d", k), {31'd0, ready[1]}, (k == 3) ? 32'h1 : 32'h0);
      chk($sformatf("slow_bus_T%0d", k), {16'd0, busv[1]}, (k == 3) ? 32'hA5A5 : 32'hFFFF);
      step();
    end

    // Pending write aborted by reset
    issue(1, 1'b1, 12'h080, 16'h5A5A);
    seen = 0;
    @(negedge clk); seen |= ready[1];
    step();
    rst = 1'b1;
    @(negedge clk); seen |= ready[1];
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); seen |= ready[1];
      step();
    end
    chk("abort_no_ready", {31'd0, seen}, 32'h0);
    @(negedge clk);
    chk("conflict_cleared_by_rst", {31'd0, conflict[0]}, 32'h0);
    step();
    access(1, 1'b0, 12'h080, 16'h0, 3, 16'hA5A5, "abort_mem_unchanged");
    access(0, 1'b0, 12'h00A, 16'h0, 1, 16'hBEEF, "fast_after_rst");

    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
